// File: rtl/dense_layer_engine.sv
// dense_layer_engine
//   Per-layer dot-product engine that sits on the responder side of the
//   network sequencer's run/address/done handshake. It accumulates signed
//   x*w products for N_INPUTS samples, adds a bias, then applies ReLU and
//   saturation to OUT_W bits.
//
// Handshake (run/done): the sequencer raises run one cycle after it presents
//   addr=0 and holds run high until it has sampled done. done is high for
//   exactly one cycle per completed layer. After done the engine waits for run
//   to go low before it re-arms. If run falls before the last sample is
//   accepted, the run is aborted: there is no done and result is unchanged.
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   run        layer enable from the sequencer
//   addr       sequencer address; the same address drives the x/w memories
//   x_in,w_in  signed memory data for the addr of the previous cycle
//   bias       signed bias, stable while run is high
//   done       one-cycle completion pulse
//   busy       high in every state except IDLE
//   result     ReLU/saturated activation, held until the next completion
//   state_dbg  current FSM state, for debug and checkers
module dense_layer_engine #(
  parameter int N_INPUTS = 784,
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 32,
  parameter int OUT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic [31:0]              addr,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [ACC_W-1:0]  bias,
  output logic                     done,
  output logic                     busy,
  output logic signed [OUT_W-1:0]  result,
  output logic [2:0]               state_dbg
);

  localparam int IDX_W = $clog2(N_INPUTS + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ACCUM = 3'd1;
  localparam logic [2:0] ST_BIAS  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;

  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(N_INPUTS - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((2 ** (OUT_W - 1)) - 1);

  logic [2:0]               state;
  logic signed [ACC_W-1:0]  acc;
  logic [IDX_W-1:0]         idx;
  logic [31:0]              addr_d;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [ACC_W-1:0]    sum;
  logic signed [OUT_W-1:0]    act;
  logic                       accept;
  logic                       last_accept;

  // Memory data is used combinationally; addr_d tags which index it belongs to.
  assign prod     = x_in * w_in;
  assign prod_ext = ACC_W'(prod);
  assign accept   = run && (state == ST_IDLE || state == ST_ACCUM)
                    && (addr_d == 32'(idx));
  // The final product lands in acc on the same edge that moves the FSM to BIAS.
  assign last_accept = accept && (idx == IDX_LAST);

  assign sum = acc + bias;

  always_comb begin
    act = sum[OUT_W-1:0];
    if (sum[ACC_W-1]) begin
      act = '0;
    end else if (sum > OUT_MAX) begin
      act = OUT_MAX[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      acc    <= '0;
      idx    <= '0;
      addr_d <= '0;
      result <= '0;
    end else begin
      addr_d <= addr;
      if (accept) begin
        acc <= acc + prod_ext;
        idx <= idx + 1'b1;
      end
      // acc/idx are cleared whenever the FSM returns to IDLE, so a run that
      // starts immediately after an abort or a completion begins from zero.
      case (state)
        ST_IDLE: begin
          if (!run) begin
            acc <= '0;
            idx <= '0;
          end else if (last_accept) begin
            state <= ST_BIAS;
          end else begin
            state <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (!run) begin
            state <= ST_IDLE;
            acc   <= '0;
            idx   <= '0;
          end else if (last_accept) begin
            state <= ST_BIAS;
          end
        end
        ST_BIAS: begin
          result <= act;
          state  <= ST_DONE;
        end
        ST_DONE: state <= ST_WAIT;
        ST_WAIT: begin
          if (!run) begin
            state <= ST_IDLE;
            acc   <= '0;
            idx   <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign done      = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_dense_layer_engine.sv
// tb_dense_layer_engine
//   Directed bench for dense_layer_engine with N_INPUTS=4. A sequencer model
//   drives addr 0,1,2,3,3,... with optional gaps and raises run one cycle late.
//   It drops run the cycle after it samples done, or after an abort or reset
//   point. A one-cycle-latency memory model feeds x_in/w_in. Inputs change on
//   the falling edge, and outputs are sampled there before the new inputs are
//   applied.
module tb_dense_layer_engine;

  localparam int N_INPUTS = 4;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 32;
  localparam int OUT_W    = 16;
  localparam int RUN_CYC  = 30;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     run;
  logic [31:0]              addr;
  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] w_in;
  logic signed [ACC_W-1:0]  bias;
  logic                     done;
  logic                     busy;
  logic [OUT_W-1:0]         result;
  logic [2:0]               state_dbg;

  logic signed [DATA_W-1:0] x_mem [N_INPUTS];
  logic signed [DATA_W-1:0] w_mem [N_INPUTS];

  logic [OUT_W-1:0] exp_q [$];

  int total = 0;
  int bad   = 0;
  int done_cnt;
  int done_at;
  int busy_rise;
  int busy_fall;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  dense_layer_engine #(
    .N_INPUTS(N_INPUTS),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .addr     (addr),
    .x_in     (x_in),
    .w_in     (w_in),
    .bias     (bias),
    .done     (done),
    .busy     (busy),
    .result   (result),
    .state_dbg(state_dbg)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, $signed(got), $signed(exp));
    end
  endtask

  task automatic check_result(input string tag);
    logic [OUT_W-1:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got=%0d exp=<empty queue>", tag, result);
    end else begin
      e = exp_q.pop_front();
      check_val(tag, 32'(result), 32'(e));
    end
  endtask

  // ---------------- drivers ----------------
  task automatic load_mem(input int x0, input int x1, input int x2, input int x3,
                          input int w0, input int w1, input int w2, input int w3);
    x_mem[0] = DATA_W'(x0); x_mem[1] = DATA_W'(x1);
    x_mem[2] = DATA_W'(x2); x_mem[3] = DATA_W'(x3);
    w_mem[0] = DATA_W'(w0); w_mem[1] = DATA_W'(w1);
    w_mem[2] = DATA_W'(w2); w_mem[3] = DATA_W'(w3);
  endtask

  // One sequencer-driven layer run of RUN_CYC cycles followed by an idle tail.
  //   gap        extra cycles addr is held at 1 before it moves on
  //   extra_hold extra cycles run stays high after done is sampled
  //   abort_at   cycle from which run is forced low (0 = never)
  //   rst_at     cycle in which rst is pulsed (0 = never)
  //   rst_drop   drop run after the reset pulse
  task automatic run_layer(input int gap, input int extra_hold, input int abort_at,
                           input int rst_at, input bit rst_drop);
    int  a;
    bit  run_v;
    done_cnt  = 0;
    done_at   = -1;
    busy_rise = -1;
    busy_fall = -1;
    for (int k = 0; k < RUN_CYC; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
      if (busy && busy_rise < 0) busy_rise = k;
      if (!busy && busy_rise >= 0 && busy_fall < 0) busy_fall = k;

      if (k == 0)                                 run_v = 1'b0;
      else if (done_at >= 0 && k > done_at + extra_hold) run_v = 1'b0;
      else if (abort_at > 0 && k >= abort_at)     run_v = 1'b0;
      else if (rst_at > 0 && rst_drop && k > rst_at) run_v = 1'b0;
      else                                        run_v = 1'b1;

      // Memory output for the address presented last cycle.
      x_in = x_mem[addr[1:0]];
      w_in = w_mem[addr[1:0]];

      if (k <= 1)            a = k;
      else if (k <= 1 + gap) a = 1;
      else                   a = (k - gap > N_INPUTS - 1) ? N_INPUTS - 1 : k - gap;

      addr = 32'(a);
      run  = run_v;
      rst  = (rst_at > 0 && k == rst_at);
    end
    run = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst  = 1'b1;
    run  = 1'b0;
    addr = '0;
    x_in = '0;
    w_in = '0;
    bias = '0;
    load_mem(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_val("rst_done",   32'(done),      32'd0);
    check_val("rst_busy",   32'(busy),      32'd0);
    check_val("rst_result", 32'(result),    32'd0);
    check_val("rst_state",  32'(state_dbg), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic: 1+2+3+4 - 5 = 5, done at R+5 (R=1).
    load_mem(1, 2, 3, 4, 1, 1, 1, 1);
    bias = -32'sd5;
    exp_q.push_back(16'd5);
    run_layer(0, 0, 0, 0, 1'b0);
    check_result("basic_result");
    check_val("basic_done_cnt",  32'(done_cnt),  32'd1);
    check_val("basic_done_at",   32'(done_at),   32'd6);
    check_val("basic_busy_rise", 32'(busy_rise), 32'd2);
    check_val("basic_busy_fall", 32'(busy_fall), 32'd8);
    check_val("basic_busy_end",  32'(busy),      32'd0);

    // ReLU: -10 -> 0.
    load_mem(1, 2, 3, 4, -1, -1, -1, -1);
    bias = 32'sd0;
    exp_q.push_back(16'd0);
    run_layer(0, 0, 0, 0, 1'b0);
    check_result("relu_result");
    check_val("relu_done_cnt", 32'(done_cnt), 32'd1);

    // Mixed signs: -12-30+14-18 = -46, +100 -> 54.
    load_mem(-3, 5, 7, -2, 4, -6, 2, 9);
    bias = 32'sd100;
    exp_q.push_back(16'd54);
    run_layer(0, 0, 0, 0, 1'b0);
    check_result("mixed_result");

    // Saturation: 4*127*127 = 64516 -> 32767.
    load_mem(127, 127, 127, 127, 127, 127, 127, 127);
    bias = 32'sd0;
    exp_q.push_back(16'd32767);
    run_layer(0, 0, 0, 0, 1'b0);
    check_result("sat_pos_result");

    // Saturation: 4*(-128*-128) = 65536 -> 32767.
    load_mem(-128, -128, -128, -128, -128, -128, -128, -128);
    exp_q.push_back(16'd32767);
    run_layer(0, 0, 0, 0, 1'b0);
    check_result("sat_neg_result");
    check_val("sat_neg_done_cnt", 32'(done_cnt), 32'd1);

    // Abort after 2 accepts: no done, previous result (32767) held.
    load_mem(1, 2, 3, 4, 1, 1, 1, 1);
    bias = -32'sd5;
    exp_q.push_back(16'd32767);
    run_layer(0, 0, 3, 0, 1'b0);
    check_result("abort_result_held");
    check_val("abort_done_cnt", 32'(done_cnt), 32'd0);
    check_val("abort_busy_end", 32'(busy),     32'd0);

    // Fresh run after the abort.
    exp_q.push_back(16'd5);
    run_layer(0, 0, 0, 0, 1'b0);
    check_result("fresh_result");
    check_val("fresh_done_cnt", 32'(done_cnt), 32'd1);
    check_val("fresh_done_at",  32'(done_at),  32'd6);

    // Sequencer keeps run high 5 extra cycles while addr stays at 3.
    exp_q.push_back(16'd5);
    run_layer(0, 5, 0, 0, 1'b0);
    check_result("hold_result");
    check_val("hold_done_cnt",  32'(done_cnt),  32'd1);
    check_val("hold_busy_fall", 32'(busy_fall), 32'd13);

    // Address gap of 2 cycles at addr=1: done delayed by 2.
    exp_q.push_back(16'd5);
    run_layer(2, 0, 0, 0, 1'b0);
    check_result("gap_result");
    check_val("gap_done_at", 32'(done_at), 32'd8);

    // Reset at the third accept: result cleared, no done.
    exp_q.push_back(16'd0);
    run_layer(0, 0, 0, 3, 1'b1);
    check_result("rst_mid_result");
    check_val("rst_mid_done_cnt", 32'(done_cnt), 32'd0);
    check_val("rst_mid_busy",     32'(busy),     32'd0);

    // rst and run high together in cycle R: sample 0 is lost, so the run
    // never completes while run stays high.
    exp_q.push_back(16'd0);
    run_layer(0, 0, 0, 1, 1'b0);
    check_result("rst_run_result");
    check_val("rst_run_done_cnt", 32'(done_cnt), 32'd0);
    check_val("rst_run_busy_end", 32'(busy),     32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
